// File: rtl/fifo_tx_defs_pkg.sv
// Shared definitions for the FIFO-draining serial transmitter.
// Holds the 3-bit state encoding, parity-mode constants, the legal
// stop-bit values and a small parity helper used when a byte is loaded.
package fifo_tx_defs;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    LOAD   = ST_LOAD,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Even parity is the plain XOR of the byte; odd parity inverts it.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_tx_baud.sv
// Bit-period timer for fifo_serial_tx.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   restart    : reload the period so a fresh bit starts next cycle
//   tick       : high on the last cycle of each CLKS_PER_BIT period
module fifo_tx_baud #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart || (cnt_q == 16'd0)) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == 16'd0);

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a 16x8 synchronous FIFO one byte at a time onto an async serial
// line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous abort back to IDLE (highest priority)
//   en          : allows new bytes to be fetched (looked at in IDLE/STOP)
//   fifo_empty  : FIFO empty flag
//   fifo_dout   : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     : one-cycle pop strobe
//   txd         : serial output, idle high, registered
//   busy        : high whenever not IDLE
//   frame_done  : pulse on the last cycle of the final stop bit
//   dbg_state   : current FSM state for observation
//
// FIFO read handshake: a pop is requested only when fifo_empty was seen low
// at the clock edge entering FETCH; fifo_rd is high for exactly the FETCH
// cycle and the popped byte is taken from fifo_dout at the end of LOAD.
module fifo_serial_tx
  import fifo_tx_defs::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = PAR_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] dbg_state
);

  state_e      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        restart;
  logic        tick;
  logic        last_stop;

  fifo_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // With two stop bits the first stop period only advances stop_q.
  assign last_stop = (STOP_BITS == STOP_BITS_MAX) ? stop_q : 1'b1;

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    restart    = 1'b0;
    frame_done = 1'b0;
    if (clr) begin
      state_d = IDLE;
      bit_d   = 3'd0;
      stop_d  = 1'b0;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && !fifo_empty) state_d = FETCH;
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          shreg_d = fifo_dout;
          par_d   = parity_of(fifo_dout, PARITY_ODD);
          restart = 1'b1;
          state_d = START;
        end
        START: begin
          if (tick) state_d = DATA;
        end
        DATA: begin
          if (tick) begin
            shreg_d = {1'b0, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick) state_d = STOP;
        end
        STOP: begin
          if (tick) begin
            if (last_stop) begin
              frame_done = 1'b1;
              stop_d     = 1'b0;
              state_d    = (en && !fifo_empty) ? FETCH : IDLE;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // txd is registered from the next state so the line changes exactly at
  // the state boundary without any combinational path to the pin.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign fifo_rd   = (state_q == FETCH);
  assign busy      = (state_q != IDLE);
  assign txd       = txd_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

  localparam int C = 4;
  // Per-instance configuration: 0 = 8N1, 1 = even parity 1 stop,
  // 2 = odd parity 2 stops.
  localparam int PE_A [3] = '{0, 1, 1};
  localparam int PO_A [3] = '{0, 0, 1};
  localparam int SB_A [3] = '{1, 1, 2};
  localparam int LEN_A [3] = '{40, 44, 48};

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         exp_len;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       en;
  logic       fifo_empty_v [3];
  logic [7:0] dout_v [3];
  logic       rd_v [3];
  logic       txd_v [3];
  logic       busy_v [3];
  logic       fd_v [3];
  logic [2:0] dbg_v [3];

  logic [7:0] fmem [3][16];
  int         fhead [3];
  int         fcnt [3];
  int         rd_cnt [3];
  int         rd_empty_err;

  logic [7:0] exp_q [$];
  int         n_pass;
  int         n_total;
  vec_t       vecs [8];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .fifo_empty(fifo_empty_v[0]),
    .fifo_dout(dout_v[0]), .fifo_rd(rd_v[0]), .txd(txd_v[0]), .busy(busy_v[0]),
    .frame_done(fd_v[0]), .dbg_state(dbg_v[0]));

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .fifo_empty(fifo_empty_v[1]),
    .fifo_dout(dout_v[1]), .fifo_rd(rd_v[1]), .txd(txd_v[1]), .busy(busy_v[1]),
    .frame_done(fd_v[1]), .dbg_state(dbg_v[1]));

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .fifo_empty(fifo_empty_v[2]),
    .fifo_dout(dout_v[2]), .fifo_rd(rd_v[2]), .txd(txd_v[2]), .busy(busy_v[2]),
    .frame_done(fd_v[2]), .dbg_state(dbg_v[2]));

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Advance to the next falling edge and service the FIFO models there.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rd_v[i] === 1'b1) begin
        rd_cnt[i]++;
        if (fcnt[i] == 0) begin
          rd_empty_err++;
        end else begin
          dout_v[i] = fmem[i][fhead[i]];
          fhead[i]  = (fhead[i] + 1) % 16;
          fcnt[i]--;
        end
      end
      fifo_empty_v[i] = (fcnt[i] == 0);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    fmem[inst][(fhead[inst] + fcnt[inst]) % 16] = b;
    fcnt[inst]++;
    fifo_empty_v[inst] = 1'b0;
  endtask

  // Called at the sample point of the first START cycle; walks the whole
  // frame cycle by cycle against a model built from the popped byte.
  task automatic check_frame(input int inst, input int exp_len, input int drop_en_k);
    logic [7:0]  exp_b;
    logic [7:0]  got_b;
    logic [11:0] bits;
    int          nbits, len, wave_err, busy_err, fd_at, fd_cnt, idx;
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    exp_b = exp_q.pop_front();
    got_b = 8'h00;
    bits  = '1;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[1 + j] = exp_b[j];
    idx = 9;
    if (PE_A[inst] != 0) begin
      bits[9] = (^exp_b) ^ PO_A[inst][0];
      idx = 10;
    end
    nbits = idx + SB_A[inst];
    len = nbits * C;
    wave_err = 0; busy_err = 0; fd_at = -1; fd_cnt = 0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) step();
      if (k == drop_en_k) en = 1'b0;
      if (txd_v[inst] !== bits[k / C]) wave_err++;
      if (busy_v[inst] !== 1'b1) busy_err++;
      if (fd_v[inst] === 1'b1) begin
        fd_cnt++;
        if (fd_at < 0) fd_at = k;
      end
      if ((k % C) == C / 2 && (k / C) >= 1 && (k / C) <= 8) got_b[(k / C) - 1] = txd_v[inst];
    end
    chk("frame_wave_errs", wave_err, 0);
    chk("frame_busy_errs", busy_err, 0);
    chk("sb_byte", got_b, exp_b);
    chk("frame_done_at", fd_at, exp_len - 1);
    chk("frame_done_cnt", fd_cnt, 1);
  endtask

  // Entered at the falling edge where a byte has just become available
  // (or en just rose) with the instance idle.
  task automatic send_one(input int inst, input int exp_len, input int drop_en_k);
    step();
    chk("fetch_rd", rd_v[inst], 1);
    step();
    chk("load_rd_txd", {rd_v[inst], txd_v[inst]}, 2'b01);
    step();
    chk("start_txd", txd_v[inst], 0);
    check_frame(inst, exp_len, drop_en_k);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    n_pass = 0; n_total = 0; rd_empty_err = 0;
    rst_n = 1'b0; clr = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fhead[i] = 0; fcnt[i] = 0; rd_cnt[i] = 0;
      fifo_empty_v[i] = 1'b1; dout_v[i] = 8'h00;
    end

    vecs[0] = '{0, 8'hA5, 40};
    vecs[1] = '{0, 8'h3C, 40};
    vecs[2] = '{1, 8'h07, 44};
    vecs[3] = '{2, 8'h07, 48};
    vecs[4] = '{2, 8'h3C, 48};
    for (int v = 5; v < 8; v++) begin
      vecs[v].inst    = int'($urandom_range(0, 2));
      vecs[v].data    = 8'($urandom_range(0, 255));
      vecs[v].exp_len = LEN_A[vecs[v].inst];
    end

    // reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_outs", {txd_v[i], rd_v[i], busy_v[i], fd_v[i]}, 4'b1000);
    end
    chk("reset_state", dbg_v[0], 3'd0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (6) step();
    chk("idle_while_empty", {busy_v[0], busy_v[1], busy_v[2]}, 3'b000);
    chk("no_rd_while_empty", rd_cnt[0] + rd_cnt[1] + rd_cnt[2], 0);

    // table-driven single frames
    for (int v = 0; v < 8; v++) begin
      r0 = rd_cnt[vecs[v].inst];
      push(vecs[v].inst, vecs[v].data);
      exp_q.push_back(vecs[v].data);
      send_one(vecs[v].inst, vecs[v].exp_len, -1);
      step();
      chk("busy_drop", busy_v[vecs[v].inst], 0);
      chk("rd_once", rd_cnt[vecs[v].inst] - r0, 1);
    end

    // back-to-back 0x00 then 0xFF
    r0 = rd_cnt[0];
    push(0, 8'h00); push(0, 8'hFF);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send_one(0, 40, -1);
    step();
    chk("b2b_fetch", {rd_v[0], txd_v[0]}, 2'b11);
    step();
    chk("b2b_load", {rd_v[0], txd_v[0]}, 2'b01);
    step();
    chk("b2b_start", txd_v[0], 0);
    check_frame(0, 40, -1);
    step();
    chk("b2b_busy_drop", busy_v[0], 0);
    chk("b2b_rd_count", rd_cnt[0] - r0, 2);

    // en dropped mid-frame: frame completes, second byte stays queued
    r0 = rd_cnt[0];
    push(0, 8'h11); push(0, 8'h22);
    exp_q.push_back(8'h11);
    send_one(0, 40, 20);
    step();
    chk("en_drop_idle", busy_v[0], 0);
    repeat (8) step();
    chk("en_drop_rd_count", rd_cnt[0] - r0, 1);
    chk("en_drop_fifo_left", fcnt[0], 1);
    exp_q.push_back(8'h22);
    en = 1'b1;
    send_one(0, 40, -1);
    step();
    chk("en_resume_busy_drop", busy_v[0], 0);

    // clr during data bit 3
    push(0, 8'h5A);
    step(); step(); step();
    chk("clr_pre_start", txd_v[0], 0);
    repeat (17) step();
    clr = 1'b1;
    step();
    chk("clr_abort", {txd_v[0], busy_v[0]}, 2'b10);
    chk("clr_state", dbg_v[0], 3'd0);
    clr = 1'b0;
    repeat (4) step();
    chk("clr_stays_idle", busy_v[0], 0);
    push(0, 8'h6B);
    exp_q.push_back(8'h6B);
    send_one(0, 40, -1);
    step();
    chk("clr_after_busy_drop", busy_v[0], 0);

    // asynchronous reset in the middle of DATA
    push(0, 8'hC3);
    step(); step(); step();
    repeat (10) step();
    chk("pre_reset_busy", busy_v[0], 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {txd_v[0], rd_v[0], busy_v[0], fd_v[0]}, 4'b1000);
    chk("rst_mid_state", dbg_v[0], 3'd0);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("rst_then_idle", busy_v[0], 0);

    chk("rd_never_when_empty", rd_empty_err, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
